nios2_computer_switches_irq_ctrl: RTL and testbench

//  Avalon-MM slave controlling the slide-switch input port: synchronises and debounces in_port,

---
 rtl/nios2_computer_pio_pkg.sv | 30 +++
 rtl/switch_debounce_bit.sv | 52 +++++
 rtl/nios2_computer_switches_irq_ctrl.sv | 100 ++++++++++
 tb/tb_nios2_computer_switches_irq_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/nios2_computer_pio_pkg.sv
// Shared definitions for the switch PIO replacement: register map, edge-select
// encodings and CONTROL field positions.
package nios2_computer_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd1;
  localparam logic [1:0] ADDR_EDGECAP = 2'd2;
  localparam logic [1:0] ADDR_CONTROL = 2'd3;

  localparam int unsigned CTRL_W          = 3;
  localparam int unsigned CTRL_EDGE_LSB   = 0;
  localparam int unsigned CTRL_EDGE_MSB   = 1;
  localparam int unsigned CTRL_BYPASS_BIT = 2;

  typedef enum logic [1:0] {
    EdgeOff  = 2'b00,
    EdgeRise = 2'b01,
    EdgeFall = 2'b10,
    EdgeBoth = 2'b11
  } edge_sel_e;

  function automatic logic rise_en(edge_sel_e sel);
    return (sel == EdgeRise) || (sel == EdgeBoth);
  endfunction

  function automatic logic fall_en(edge_sel_e sel);
    return (sel == EdgeFall) || (sel == EdgeBoth);
  endfunction

endpackage

// File: rtl/switch_debounce_bit.sv
// One switch input: 2-FF synchroniser followed by a stability counter that only
// accepts a new level after it has been held for DebounceCycles cycles.
module switch_debounce_bit #(
  parameter int unsigned DebounceCycles = 50000,
  parameter int unsigned CntW           = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  input  logic bypass_i,
  output logic deb_o
);

  localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

  logic            meta_q, sync_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            deb_q, deb_d;

  // Any cycle where sync matches the accepted level leaves cnt_d at 0, which is
  // what rejects glitches shorter than the debounce window.
  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (bypass_i) begin
      deb_d = sync_q;
    end else if (sync_q != deb_q) begin
      if (cnt_q == CntMax) begin
        deb_d = sync_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      cnt_q  <= '0;
      deb_q  <= 1'b0;
    end else begin
      meta_q <= raw_i;
      sync_q <= meta_q;
      cnt_q  <= cnt_d;
      deb_q  <= deb_d;
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/nios2_computer_switches_irq_ctrl.sv
// Avalon-MM slave for the slide switches: debounced data, per-bit edge capture
// with W1C clear, interrupt mask and a registered level interrupt.
module nios2_computer_switches_irq_ctrl
  import nios2_computer_pio_pkg::*;
#(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0]  deb, deb_dly_q;
  logic [WIDTH-1:0]  mask_q, mask_d;
  logic [WIDTH-1:0]  cap_q, cap_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              irq_q, irq_d;
  logic              wr_en;
  logic [WIDTH-1:0]  rise, fall, set_v, w1c;
  edge_sel_e         edge_sel;
  logic              unused_wdata;

  assign unused_wdata = ^writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_deb
    switch_debounce_bit #(
      .DebounceCycles(DEBOUNCE_CYCLES),
      .CntW          (CNT_W)
    ) u_deb (
      .clk_i   (clk),
      .rst_ni  (reset_n),
      .raw_i   (in_port[i]),
      .bypass_i(ctrl_q[CTRL_BYPASS_BIT]),
      .deb_o   (deb[i])
    );
  end

  assign wr_en    = chipselect && !write_n;
  assign edge_sel = edge_sel_e'(ctrl_q[CTRL_EDGE_MSB:CTRL_EDGE_LSB]);
  assign rise     = deb & ~deb_dly_q;
  assign fall     = ~deb & deb_dly_q;

  always_comb begin
    mask_d = mask_q;
    ctrl_d = ctrl_q;
    w1c    = '0;
    if (wr_en) begin
      if (address == ADDR_IRQMASK) mask_d = writedata[WIDTH-1:0];
      if (address == ADDR_CONTROL) ctrl_d = writedata[CTRL_W-1:0];
      if (address == ADDR_EDGECAP) w1c = writedata[WIDTH-1:0];
    end
    set_v = (rise_en(edge_sel) ? rise : '0) | (fall_en(edge_sel) ? fall : '0);
    // A new edge wins over a clear of the same bit so no event is lost.
    cap_d = (cap_q & ~w1c) | set_v;
    irq_d = |(cap_q & mask_q);
  end

  // Read mux is not gated by chipselect, matching the original PIO.
  always_comb begin
    rdata_d = '0;
    unique case (address)
      ADDR_DATA:    rdata_d[WIDTH-1:0]  = deb;
      ADDR_IRQMASK: rdata_d[WIDTH-1:0]  = mask_q;
      ADDR_EDGECAP: rdata_d[WIDTH-1:0]  = cap_q;
      ADDR_CONTROL: rdata_d[CTRL_W-1:0] = ctrl_q;
      default:      rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_dly_q <= '0;
      mask_q    <= '0;
      cap_q     <= '0;
      ctrl_q    <= '0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      deb_dly_q <= deb;
      mask_q    <= mask_d;
      cap_q     <= cap_d;
      ctrl_q    <= ctrl_d;
      rdata_q   <= rdata_d;
      irq_q     <= irq_d;
    end
  end

  assign readdata = rdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_nios2_computer_switches_irq_ctrl.sv
// Scoreboard bench: each read pushes its expected readdata/irq; a monitor pops
// and compares when the registered read data is presented one cycle later.
module tb_nios2_computer_switches_irq_ctrl;

  localparam logic [1:0] A_DATA = 2'd0, A_MASK = 2'd1, A_CAP = 2'd2, A_CTRL = 2'd3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  in_port;
  logic        irq;
  logic        rd_issue = 1'b0;

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        chk_irq;
    logic        irq_v;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  nios2_computer_switches_irq_ctrl #(
    .WIDTH          (8),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (16)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .irq       (irq)
  );

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic chk(input string nm, input logic [1:0] a, input logic [31:0] d,
                     input logic ci, input logic iv);
    exp_t e;
    e.name    = nm;
    e.data    = d;
    e.chk_irq = ci;
    e.irq_v   = iv;
    sb_q.push_back(e);
    address  = a;
    rd_issue = 1'b1;
    @(posedge clk);
    #1;
    rd_issue = 1'b0;
  endtask

  task automatic chk_now(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Monitor: readdata for a read issued in cycle k is valid after edge k+1.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (rd_issue) begin
        #2;
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_empty: got read with no expected entry, required one");
        end else begin
          e = sb_q.pop_front();
          total++;
          if (readdata !== e.data) begin
            bad++;
            $display("FAIL %s: readdata=%h expected %h", e.name, readdata, e.data);
          end
          if (e.chk_irq) begin
            total++;
            if (irq !== e.irq_v) begin
              bad++;
              $display("FAIL %s_irq: irq=%b expected %b", e.name, irq, e.irq_v);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    in_port    = 8'hA5;
    address    = A_DATA;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;

    // Reset with switches held at A5, then debounce latency.
    cyc(2);
    chk("rst_data", A_DATA, 32'h0, 1'b1, 1'b0);
    reset_n = 1'b1;
    cyc(4);
    chk("deb_early", A_DATA, 32'h0, 1'b1, 1'b0);
    cyc(1);
    chk("deb_a5", A_DATA, 32'hA5, 1'b1, 1'b0);
    chk("cap_rst", A_CAP, 32'h0, 1'b1, 1'b0);

    // Glitch rejection on bit0.
    in_port = 8'hA4;
    cyc(8);
    chk("data_a4", A_DATA, 32'hA4, 1'b0, 1'b0);
    wr(A_CTRL, 32'h3);
    chk("ctrl_3", A_CTRL, 32'h3, 1'b0, 1'b0);
    in_port = 8'hA5;
    cyc(3);
    in_port = 8'hA4;
    cyc(8);
    chk("glitch_data", A_DATA, 32'hA4, 1'b0, 1'b0);
    chk("glitch_cap", A_CAP, 32'h0, 1'b0, 1'b0);
    in_port = 8'hA5;
    cyc(8);
    chk("stable_data", A_DATA, 32'hA5, 1'b0, 1'b0);
    chk("stable_cap", A_CAP, 32'h1, 1'b1, 1'b0);
    wr(A_CAP, 32'hFF);
    chk("cap_clr_all", A_CAP, 32'h0, 1'b0, 1'b0);

    // Rising-only capture with bit0 interrupt enabled.
    wr(A_CTRL, 32'h1);
    wr(A_MASK, 32'h1);
    chk("mask_1", A_MASK, 32'h1, 1'b0, 1'b0);
    in_port = 8'hA4;
    cyc(8);
    chk("fall_ignored", A_CAP, 32'h0, 1'b1, 1'b0);
    in_port = 8'hA5;
    cyc(6);
    chk("cap_pre", A_CAP, 32'h0, 1'b1, 1'b0);
    chk("cap_set", A_CAP, 32'h1, 1'b1, 1'b1);
    wr(A_CAP, 32'h1);
    chk("cap_w1c", A_CAP, 32'h0, 1'b1, 1'b0);

    // Set beats simultaneous W1C on bit3.
    in_port = 8'hAD;
    cyc(8);
    chk("bit3_rise", A_CAP, 32'h8, 1'b1, 1'b0);
    wr(A_CTRL, 32'h3);
    in_port = 8'hA5;
    cyc(6);
    wr(A_CAP, 32'h8);
    chk("set_prio", A_CAP, 32'h8, 1'b1, 1'b0);
    wr(A_CAP, 32'hFF);
    chk("cap_clr2", A_CAP, 32'h0, 1'b0, 1'b0);

    // Bypass: DATA follows in_port after 3 cycles, unused bits ignored.
    wr(A_MASK, 32'hFFFF_FF00);
    chk("mask_hi_ignored", A_MASK, 32'h0, 1'b0, 1'b0);
    wr(A_CTRL, 32'h4);
    chk("ctrl_4", A_CTRL, 32'h4, 1'b0, 1'b0);
    in_port = 8'h5A;
    cyc(2);
    chk("byp_old", A_DATA, 32'hA5, 1'b0, 1'b0);
    chk("byp_new", A_DATA, 32'h5A, 1'b1, 1'b0);
    chk("byp_cap", A_CAP, 32'h0, 1'b1, 1'b0);
    wr(A_CTRL, 32'hFFFF_FFFF);
    chk("ctrl_7", A_CTRL, 32'h7, 1'b0, 1'b0);
    in_port = 8'hA5;
    cyc(5);
    chk("cap_ff_masked", A_CAP, 32'hFF, 1'b1, 1'b0);
    wr(A_MASK, 32'hFF);
    chk("mask_ff_irq", A_MASK, 32'hFF, 1'b1, 1'b1);

    // Asynchronous reset mid-debounce.
    wr(A_CTRL, 32'h3);
    in_port = 8'h00;
    cyc(3);
    reset_n = 1'b0;
    #1;
    chk_now("async_rdata", readdata, 32'h0);
    chk_now("async_irq", {31'h0, irq}, 32'h0);
    cyc(1);
    chk("rst_cap", A_CAP, 32'h0, 1'b1, 1'b0);
    reset_n = 1'b1;
    cyc(8);
    chk("post_cap", A_CAP, 32'h0, 1'b1, 1'b0);
    chk("post_mask", A_MASK, 32'h0, 1'b0, 1'b0);
    chk("post_ctrl", A_CTRL, 32'h0, 1'b0, 1'b0);
    chk("post_data", A_DATA, 32'h0, 1'b1, 1'b0);

    cyc(3);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: %0d entries left, required 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
